// File: rtl/uart_echo_fifo.sv
// UART loopback: 3-flop synchronised receiver feeds a FIFO that an independent
// transmitter drains back onto txd. Sticky error flags cover framing, parity and overflow.
module uart_echo_fifo #(
   parameter int CLK_DIV    = 5208,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rxd,
   output logic                          txd,
   input  logic                          echo_en,
   input  logic                          clr_err,
   output logic                          rx_valid,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(2 * CLK_DIV * STOP_BITS);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [CW-1:0] DIV_M1  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] STOP_M1 = CW'(STOP_BITS * CLK_DIV - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_e;
   typedef enum logic [2:0] {TX_IDLE, TX_LOAD, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_e;

   // ---------------- synchroniser ----------------
   logic [2:0] sync_q;
   logic       rxs, rxs_prev_q;
   assign rxs = sync_q[2];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q     <= 3'b111;
         rxs_prev_q <= 1'b1;
      end else begin
         sync_q     <= {sync_q[1:0], rxd};
         rxs_prev_q <= rxs;
      end
   end

   // ---------------- receiver ----------------
   rx_state_e            rx_state_q, rx_state_d;
   logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
   logic [BW-1:0]        rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
   logic                 rx_par_q, rx_par_d;
   logic                 rx_good, frame_set, par_set, par_bad;
   logic                 rx_valid_q, frame_err_q, parity_err_q, overflow_q;
   logic [DATA_BITS-1:0] rx_data_q;

   always_comb begin
      par_bad = 1'b0;
      if (PARITY == 1) par_bad = ~(^{rx_sh_q, rx_par_q});
      else if (PARITY == 2) par_bad = ^{rx_sh_q, rx_par_q};
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_par_d   = rx_par_q;
      rx_good    = 1'b0;
      frame_set  = 1'b0;
      par_set    = 1'b0;
      case (rx_state_q)
         RX_IDLE: if (rxs_prev_q && !rxs) begin
            rx_state_d = RX_START;
            rx_cnt_d   = HALF_M1;
         end
         RX_START: if (rx_cnt_q == '0) begin
            if (rxs) rx_state_d = RX_IDLE;
            else begin
               rx_state_d = RX_DATA;
               rx_cnt_d   = DIV_M1;
               rx_bit_d   = '0;
            end
         end else rx_cnt_d = rx_cnt_q - 1'b1;
         RX_DATA: if (rx_cnt_q == '0) begin
            rx_sh_d  = {rxs, rx_sh_q[DATA_BITS-1:1]};
            rx_cnt_d = DIV_M1;
            if (rx_bit_q == LAST_BIT) rx_state_d = (PARITY != 0) ? RX_PAR : RX_STOP;
            else rx_bit_d = rx_bit_q + 1'b1;
         end else rx_cnt_d = rx_cnt_q - 1'b1;
         RX_PAR: if (rx_cnt_q == '0) begin
            rx_par_d   = rxs;
            rx_cnt_d   = DIV_M1;
            rx_state_d = RX_STOP;
         end else rx_cnt_d = rx_cnt_q - 1'b1;
         RX_STOP: if (rx_cnt_q == '0) begin
            // only the first stop bit is checked; a second one just looks like idle
            rx_state_d = RX_IDLE;
            if (!rxs) frame_set = 1'b1;
            else if (par_bad) par_set = 1'b1;
            else rx_good = 1'b1;
         end else rx_cnt_d = rx_cnt_q - 1'b1;
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // ---------------- FIFO ----------------
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
   logic [AW:0]          count_q;
   logic                 full, push, pop, ovf_set;
   logic [DATA_BITS-1:0] head;

   assign full    = (count_q == FULL_CNT);
   assign push    = rx_valid_q & (~full | pop);
   assign ovf_set = rx_valid_q & full & ~pop;
   assign head    = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= rx_data_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_q   <= RX_IDLE;
         rx_cnt_q     <= '0;
         rx_bit_q     <= '0;
         rx_sh_q      <= '0;
         rx_par_q     <= 1'b0;
         rx_valid_q   <= 1'b0;
         rx_data_q    <= '0;
         frame_err_q  <= 1'b0;
         parity_err_q <= 1'b0;
         overflow_q   <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         rx_state_q   <= rx_state_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_sh_q      <= rx_sh_d;
         rx_par_q     <= rx_par_d;
         rx_valid_q   <= rx_good;
         if (rx_good) rx_data_q <= rx_sh_q;
         // a set event in the same cycle as clr_err takes priority
         frame_err_q  <= frame_set | (frame_err_q  & ~clr_err);
         parity_err_q <= par_set   | (parity_err_q & ~clr_err);
         overflow_q   <= ovf_set   | (overflow_q   & ~clr_err);
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // ---------------- transmitter ----------------
   tx_state_e            tx_state_q, tx_state_d;
   logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
   logic [BW-1:0]        tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
   logic                 tx_par_q, tx_par_d;
   logic                 txd_q, txd_d, tx_busy_q, tx_busy_d;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      txd_d      = txd_q;
      tx_busy_d  = tx_busy_q;
      pop        = 1'b0;
      case (tx_state_q)
         TX_IDLE: if (echo_en && count_q != '0) begin
            pop        = 1'b1;
            tx_sh_d    = head;
            tx_par_d   = (PARITY == 1) ? ~(^head) : ^head;
            tx_state_d = TX_LOAD;
         end
         TX_LOAD: begin
            tx_state_d = TX_START;
            tx_cnt_d   = DIV_M1;
            txd_d      = 1'b0;
            tx_busy_d  = 1'b1;
         end
         TX_START: if (tx_cnt_q == '0) begin
            tx_state_d = TX_DATA;
            tx_cnt_d   = DIV_M1;
            tx_bit_d   = '0;
            txd_d      = tx_sh_q[0];
            tx_sh_d    = tx_sh_q >> 1;
         end else tx_cnt_d = tx_cnt_q - 1'b1;
         TX_DATA: if (tx_cnt_q == '0) begin
            tx_cnt_d = DIV_M1;
            if (tx_bit_q == LAST_BIT) begin
               if (PARITY != 0) begin
                  tx_state_d = TX_PAR;
                  txd_d      = tx_par_q;
               end else begin
                  tx_state_d = TX_STOP;
                  tx_cnt_d   = STOP_M1;
                  txd_d      = 1'b1;
               end
            end else begin
               tx_bit_d = tx_bit_q + 1'b1;
               txd_d    = tx_sh_q[0];
               tx_sh_d  = tx_sh_q >> 1;
            end
         end else tx_cnt_d = tx_cnt_q - 1'b1;
         TX_PAR: if (tx_cnt_q == '0) begin
            tx_state_d = TX_STOP;
            tx_cnt_d   = STOP_M1;
            txd_d      = 1'b1;
         end else tx_cnt_d = tx_cnt_q - 1'b1;
         TX_STOP: if (tx_cnt_q == '0) begin
            tx_state_d = TX_IDLE;
            tx_busy_d  = 1'b0;
         end else tx_cnt_d = tx_cnt_q - 1'b1;
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         txd_q      <= 1'b1;
         tx_busy_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         txd_q      <= txd_d;
         tx_busy_q  <= tx_busy_d;
      end
   end

   assign txd        = txd_q;
   assign tx_busy    = tx_busy_q;
   assign rx_valid   = rx_valid_q;
   assign rx_data    = rx_data_q;
   assign fifo_count = count_q;
   assign frame_err  = frame_err_q;
   assign parity_err = parity_err_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// Directed bench for uart_echo_fifo: 16 clk/bit, 8E1, 4-deep FIFO.
module tb_uart_echo_fifo;
   logic       clk = 1'b0;
   logic       rst, rxd, echo_en, clr_err;
   logic       txd, rx_valid, tx_busy, frame_err, parity_err, overflow;
   logic [7:0] rx_data;
   logic [2:0] fifo_count;

   int n_tests = 0;
   int n_fail  = 0;
   int rx_cnt  = 0;
   logic [7:0] rx_last = 8'h00;

   uart_echo_fifo #(
      .CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
   ) dut (
      .clk(clk), .rst(rst), .rxd(rxd), .txd(txd), .echo_en(echo_en),
      .clr_err(clr_err), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_busy(tx_busy), .fifo_count(fifo_count), .frame_err(frame_err),
      .parity_err(parity_err), .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_valid === 1'b1) begin
         rx_cnt  <= rx_cnt + 1;
         rx_last <= rx_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      logic [10:0] f;
      f = {stop, par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk) rxd = f[i];
         repeat (15) @(negedge clk);
      end
      @(negedge clk) rxd = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // wait (bounded) for a start bit, then sample 11 bits mid-bit; wait_n = negedges waited
   task automatic cap_tx(input string tag, output logic [10:0] bits, output int wait_n);
      bits   = '1;
      wait_n = 0;
      do begin
         @(negedge clk);
         wait_n++;
      end while (txd !== 1'b0 && wait_n < 400);
      if (txd !== 1'b0) begin
         chk({tag, "_start"}, 32'(txd), 32'h0);
         return;
      end
      repeat (8) @(negedge clk);
      bits[0] = txd;
      for (int i = 1; i < 11; i++) begin
         repeat (16) @(negedge clk);
         bits[i] = txd;
      end
   endtask

   task automatic pulse_clr();
      @(negedge clk) clr_err = 1'b1;
      @(negedge clk) clr_err = 1'b0;
   endtask

   logic [10:0] bits;
   int          w, lows;
   logic [10:0] exp_echo [4] = '{11'h602, 11'h604, 11'h406, 11'h608};

   initial begin
      rst = 1'b0; rxd = 1'b1; echo_en = 1'b1; clr_err = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_txd",   32'(txd), 32'h1);
      chk("rst_busy",  32'(tx_busy), 32'h0);
      chk("rst_valid", 32'(rx_valid), 32'h0);
      chk("rst_data",  32'(rx_data), 32'h0);
      chk("rst_count", 32'(fifo_count), 32'h0);
      chk("rst_flags", 32'({frame_err, parity_err, overflow}), 32'h0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      // 1: good frame A5 echoes as start,10100101,parity0,stop -> 11'h54A
      fork
         send_frame(8'hA5, 1'b0, 1'b1);
         cap_tx("t1", bits, w);
      join
      chk("t1_rxcnt", 32'(rx_cnt), 32'd1);
      chk("t1_rxdata", 32'(rx_last), 32'hA5);
      chk("t1_echo", 32'(bits), 32'h54A);
      repeat (20) @(negedge clk);
      chk("t1_count", 32'(fifo_count), 32'h0);
      chk("t1_busy", 32'(tx_busy), 32'h0);

      // 2: 3C has even ones, parity bit 1 is wrong
      send_frame(8'h3C, 1'b1, 1'b1);
      repeat (20) @(negedge clk);
      chk("t2_perr", 32'(parity_err), 32'h1);
      chk("t2_count", 32'(fifo_count), 32'h0);
      chk("t2_rxcnt", 32'(rx_cnt), 32'd1);
      pulse_clr();
      chk("t2_clr", 32'(parity_err), 32'h0);

      // 3: five frames into a 4-deep FIFO with echo held off
      echo_en = 1'b0;
      for (int i = 1; i <= 5; i++) send_frame(8'(i), ^(8'(i)), 1'b1);
      chk("t3_count", 32'(fifo_count), 32'd4);
      chk("t3_ovf", 32'(overflow), 32'h1);
      chk("t3_rxcnt", 32'(rx_cnt), 32'd6);
      chk("t3_rxdata", 32'(rx_last), 32'h05);
      @(negedge clk) echo_en = 1'b1;
      for (int k = 0; k < 4; k++) begin
         cap_tx("t3", bits, w);
         chk($sformatf("t3_echo%0d", k), 32'(bits), 32'(exp_echo[k]));
         // stop sample to next start: 8 stop cycles + IDLE + LOAD
         if (k > 0) chk($sformatf("t3_gap%0d", k), 32'(w), 32'd10);
      end
      repeat (20) @(negedge clk);
      chk("t3_drained", 32'(fifo_count), 32'h0);
      pulse_clr();
      chk("t3_clr", 32'(overflow), 32'h0);

      // 4: stop bit low
      send_frame(8'h55, 1'b0, 1'b0);
      repeat (20) @(negedge clk);
      chk("t4_ferr", 32'(frame_err), 32'h1);
      chk("t4_rxcnt", 32'(rx_cnt), 32'd6);
      chk("t4_count", 32'(fifo_count), 32'h0);
      pulse_clr();
      chk("t4_clr", 32'(frame_err), 32'h0);

      // 5: 6-cycle glitch, then a real frame held in the FIFO
      @(negedge clk) rxd = 1'b0;
      repeat (6) @(negedge clk);
      rxd = 1'b1;
      repeat (40) @(negedge clk);
      chk("t5_flags", 32'({frame_err, parity_err, overflow}), 32'h0);
      chk("t5_rxcnt", 32'(rx_cnt), 32'd6);
      echo_en = 1'b0;
      send_frame(8'h7E, 1'b0, 1'b1);
      chk("t5_rxcnt2", 32'(rx_cnt), 32'd7);
      chk("t5_rxdata", 32'(rx_last), 32'h7E);
      chk("t5_count", 32'(fifo_count), 32'd1);

      // 6: reset in the middle of bit 4 of the echo
      echo_en = 1'b1;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (txd !== 1'b0 && w < 400);
      chk("t6_start", 32'(txd), 32'h0);
      repeat (8 + 16 * 4) @(negedge clk);
      chk("t6_busy_pre", 32'(tx_busy), 32'h1);
      rst = 1'b0;
      #1;
      chk("t6_txd", 32'(txd), 32'h1);
      chk("t6_busy", 32'(tx_busy), 32'h0);
      chk("t6_count", 32'(fifo_count), 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      lows = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (txd !== 1'b1 || tx_busy !== 1'b0) lows++;
      end
      chk("t6_quiet", 32'(lows), 32'd0);
      chk("t6_count_post", 32'(fifo_count), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/uart_echo_fifo.md
# uart_echo_fifo

Parametrised full-duplex UART echo engine: a 3-flop synchronised receiver deserialises frames from `rxd` into a FIFO, and an independent transmitter drains that FIFO back out on `txd`. It is the next-generation board-test loopback for the UART path. It adds the following, all set by parameters:

- configurable data width, parity, stop bits and baud divisor;
- buffering across bursts;
- error detection with sticky flags.

## Interface

- `CLK_DIV`, 5208: clk cycles per bit (50 MHz / 9600 baud); must be ≥ 8.
- `DATA_BITS`, 8: data bits per frame, 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: entries; power of two, ≥ 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `rxd`  in  1  serial input, asynchronous to clk; idle high.
- `txd`  out  1  serial output; idle high.
- `echo_en`  in  1  1 = transmitter may drain the FIFO; 0 = data is held.
- `clr_err`  in  1  single-cycle pulse; clears all sticky flags.
- `rx_valid`  out  1  one-cycle strobe when a good frame is received.
- `rx_data`  out  `DATA_BITS`  last good received word.
- `tx_busy`  out  1  high while a frame is being shifted out.
- `fifo_count`  out  $clog2(`FIFO_DEPTH`)+1  current occupancy.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `parity_err`  out  1  sticky: a parity mismatch was detected.
- `overflow`  out  1  sticky: a good word was dropped because the FIFO was full.

## Operation

- **Reset values** (`rst` low, immediate): `txd`=1, `tx_busy`=0, `rx_valid`=0, `rx_data`=0, `fifo_count`=0, all flags 0, both FSMs IDLE, synchroniser flops=1.
  - Reset mid-frame abandons both frames.
  - The partial RX word is never pushed.
- **Synchroniser:** `rxd` passes through 3 flops; `rxs` is the third stage.
- **RX FSM:** IDLE → START → DATA → PARITY (only if `PARITY`≠0) → STOP → IDLE.
  - IDLE: a 1→0 transition on `rxs` loads the bit counter and enters START.
  - START: after `CLK_DIV`/2 cycles, sample `rxs`.
    - If 1: false start; return to IDLE with no flag.
    - If 0: reload `CLK_DIV`.
  - DATA: sample every `CLK_DIV` cycles, LSB first, `DATA_BITS` samples.
  - PARITY: one sample. Odd parity means the XOR of data bits and parity bit is 1; even parity means it is 0.
  - STOP: sample the first stop bit only, even when `STOP_BITS`=2.
    - If low: set `frame_err`, discard the word.
    - Else if parity mismatched: set `parity_err`, discard the word.
    - Else: the word is good.
  - The FSM returns to IDLE on the cycle of the stop sample and can detect a new start edge from the next cycle.
- **Good word:** on the cycle after the stop sample:
  - `rx_valid` pulses for 1 cycle and `rx_data` updates;
  - the word is pushed to the FIFO.
  - If the FIFO is full and not popping that cycle, the word is dropped and `overflow` is set. `rx_valid` still pulses.
- **FIFO:** circular buffer with read/write pointers of $clog2(`FIFO_DEPTH`) bits that wrap modulo `FIFO_DEPTH`.
  - Simultaneous push and pop is always accepted, including when full or empty-with-push. In that case `fifo_count` is unchanged, except empty+push gives +1 and no pop occurs.
- **TX FSM:** IDLE → LOAD → START → DATA → PARITY (optional) → STOP → IDLE.
  - IDLE: leave when `echo_en`=1 and `fifo_count`≠0. Pop the head word into the shift register; go to LOAD.
  - LOAD lasts 1 cycle.
  - Each subsequent bit is held exactly `CLK_DIV` cycles: start=0, data LSB first, parity, then `STOP_BITS` ones.
  - `echo_en` dropping mid-frame does not stop the current frame.
- **Sticky flags:** `clr_err` clears all flags. If a flag-setting event and `clr_err` occur in the same cycle, the set wins.

## Timing

- RX start edge: `rxd` falls at edge *n* → `rxs` low after edge *n*+3.
- `rx_valid` asserts 1 cycle after the stop sample.
  - That is roughly (1.5 + `DATA_BITS` + parity bit) × `CLK_DIV` + 4 cycles after the `rxd` fall.
- FIFO count updates on the clock after the push or pop.
- TX start: `fifo_count` goes nonzero with TX idle and `echo_en`=1 → pop on the next edge.
  - `txd` falls and `tx_busy` rises 2 edges after `fifo_count` goes nonzero.
  - `tx_busy` falls on the same edge the last stop bit ends.
- Back-to-back TX: the next start bit follows the last stop bit after exactly 2 idle cycles (IDLE + LOAD).
- TX frame length = (1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS`) × `CLK_DIV` cycles.

## Test plan

Configuration for all scenarios: `CLK_DIV`=16, `DATA_BITS`=8, `PARITY`=2 (even), `STOP_BITS`=1, `FIFO_DEPTH`=4.

1. Reset, then send 0xA5 with parity 0 on `rxd` at 16 cycles/bit.
   - Expect `rx_valid` pulse with `rx_data`=0xA5.
   - Expect `txd` to emit 0,1,0,1,0,0,1,0,1,0,1 (start, LSB-first data, parity, stop) at 16 cycles/bit.
2. Send 0x3C with parity bit 1.
   - Expect `parity_err`=1, no push, `fifo_count` stays 0.
   - Pulse `clr_err`; expect `parity_err`=0.
3. With `echo_en`=0, send 5 good frames 0x01–0x05.
   - Expect `fifo_count`=4 and `overflow`=1.
   - Raise `echo_en`; expect 0x01–0x04 transmitted back-to-back with 2 idle cycles between frames.
4. Send a frame with the stop bit driven low.
   - Expect `frame_err`=1, no `rx_valid`, `fifo_count` unchanged.
5. Pulse `rxd` low for 6 cycles only.
   - Expect no flags and RX back in IDLE.
   - A following 0x7E frame is received correctly.
6. Assert `rst` low mid-TX frame (bit 4).
   - Expect `txd`=1, `tx_busy`=0 and `fifo_count`=0 immediately, without waiting for a clk edge.
   - After release, no output until a new frame arrives.
